ascii_hex_parser: RTL
=====================

Name: ascii_hex_parser

Overview:
- Converts a serial stream of ASCII hex characters (e.g. from a UART RX path) into binary words: text-to-binary, the inverse of the nibble/hex display path.
- Accumulates up to NIBBLES hex digits MSB-first and emits one word over a valid/ready handshake.
- Words end when NIBBLES digits are received or when a terminator character arrives.
- Sits between the character receiver and command/register logic.

Parameters:
- NIBBLES, 8, maximum hex digits per word; word width W = 4*NIBBLES; legal range 1..16.
- CNT_W, $clog2(NIBBLES+1), width of the digit counter.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_char_valid  input  1  character present on i_char.
- i_char  input  8  ASCII character.
- o_char_ready  output  1  parser accepts a character this cycle.
- o_word_valid  output  1  o_word holds a completed word.
- o_word  output  W  parsed value, right-aligned, zero-extended.
- o_word_digits  output  CNT_W  number of digits in o_word (1..NIBBLES).
- i_word_ready  input  1  downstream consumes the word.
- o_err  output  1  one-cycle pulse when an illegal character is dropped.

Behaviour:
- Reset (async assert, sync release): state ACCUM, accumulator 0, count 0, o_word_valid 0, o_word 0, o_word_digits 0, o_err 0.
- A character is accepted on a cycle where i_char_valid && o_char_ready.
- o_char_ready = (state == ACCUM); this is combinational from state only and does not depend on i_char_valid.
- Character classes:
  - HEX: '0'-'9' (0x30-0x39), 'A'-'F' (0x41-0x46), 'a'-'f' (0x61-0x66).
  - TERM: CR 0x0D, LF 0x0A, space 0x20, comma 0x2C.
  - Everything else is ILLEGAL.
- ACCUM, HEX accepted:
  - acc <= {acc[W-5:0], nib}; count <= count+1.
  - If the new count == NIBBLES: o_word <= new acc, o_word_digits <= NIBBLES, o_word_valid <= 1, acc and count cleared, go to HOLD.
- ACCUM, TERM accepted:
  - count > 0: o_word <= acc, o_word_digits <= count, o_word_valid <= 1, acc and count cleared, go to HOLD.
  - count == 0: consumed silently. Repeated separators (e.g. CR LF) produce no empty words.
- ACCUM, ILLEGAL accepted: o_err <= 1 for exactly one cycle, acc and count cleared, partial digits discarded, no word emitted, stay in ACCUM.
- HOLD:
  - o_char_ready = 0; o_word, o_word_valid and o_word_digits are held stable.
  - When i_word_ready = 1: o_word_valid <= 0, go to ACCUM. o_char_ready is 1 from the next cycle.
- Latency: o_word_valid rises the cycle after the final digit or terminator is accepted.
- Throughput: at most one word per (digits + 1 + handshake) cycles. No character is lost because the source is back-pressured.
- A terminator immediately after an auto-emitted full word arrives with count == 0, so it is ignored.
- o_word is not cleared on handshake; only o_word_valid qualifies it.
- o_err is registered, never asserts in HOLD, and is 0 in every cycle not following an ILLEGAL accept.
- Reset mid-word or in HOLD: partial digits are lost and any pending word is dropped (o_word_valid 0 immediately on i_rst).
- i_char is ignored whenever o_char_ready = 0, regardless of i_char_valid.

Decomposition:
- Shared package ascii_hex_pkg:
  - Character constants: CH_CR, CH_LF, CH_SP, CH_COMMA, CH_0, CH_9, CH_A_UC, CH_F_UC, CH_A_LC, CH_F_LC.
  - Two-state enum parse_state_t {ACCUM, HOLD}.
- One combinational sub-module hex_char_decode:
  - Input: i_char[7:0].
  - Outputs: o_is_hex, o_is_term, o_nibble[3:0].
  - Reusable by a future binary-to-ASCII transmitter bench checker.

Test Plan:
- NIBBLES=8; send "DEADBEEF" one char per cycle, i_word_ready=1 -> o_word=32'hDEADBEEF, o_word_digits=8, valid 1 cycle after 'F'. A following CR produces no word.
- Send "1a3" then CR -> o_word=32'h0000_01A3, o_word_digits=3. Lowercase decodes the same as uppercase.
- Send CR, LF, space, "7", LF -> exactly one word 32'h7, digits=1. The leading separators produce no words and no o_err.
- Send "12G4" then CR -> o_err pulse the cycle after 'G'. The following "4",CR yields 32'h4, digits=1; 0x12 never appears.
- Complete "CAFE", LF with i_word_ready=0 for 10 cycles while i_char_valid=1 on '9' -> o_char_ready=0 throughout, o_word=32'hCAFE stable. After ready, '9' is accepted next; no character is lost.
- Assert i_rst asynchronously after "AB" and again while in HOLD -> all outputs 0 immediately. The next "5",CR yields 32'h5, digits=1.

Source files
------------

// File: rtl/ascii_hex_pkg.sv
// Shared character constants and parser state type for the ASCII hex parser.
// Also intended for reuse by a future binary-to-ASCII transmit path.
package ascii_hex_pkg;

  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_A_UC  = 8'h41;
  localparam logic [7:0] CH_F_UC  = 8'h46;
  localparam logic [7:0] CH_A_LC  = 8'h61;
  localparam logic [7:0] CH_F_LC  = 8'h66;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } parse_state_t;

endpackage

// File: rtl/hex_char_decode.sv
// Combinational classifier for one ASCII character: hex digit (with its
// nibble value), word terminator, or neither.
module hex_char_decode
  import ascii_hex_pkg::*;
(
  input  logic [7:0] i_char,
  output logic       o_is_hex,
  output logic       o_is_term,
  output logic [3:0] o_nibble
);

  always_comb begin
    o_is_hex  = 1'b0;
    o_is_term = 1'b0;
    o_nibble  = 4'h0;
    if (i_char >= CH_0 && i_char <= CH_9) begin
      o_is_hex = 1'b1;
      o_nibble = i_char[3:0];
    end else if ((i_char >= CH_A_UC && i_char <= CH_F_UC) ||
                 (i_char >= CH_A_LC && i_char <= CH_F_LC)) begin
      // 'A'/'a' have low nibble 1, so adding 9 yields 10..15
      o_is_hex = 1'b1;
      o_nibble = i_char[3:0] + 4'd9;
    end else if (i_char == CH_CR || i_char == CH_LF ||
                 i_char == CH_SP || i_char == CH_COMMA) begin
      o_is_term = 1'b1;
    end
  end

endmodule

// File: rtl/ascii_hex_parser.sv
// Accumulates ASCII hex digits MSB-first into a word and hands it downstream
// over valid/ready; the character source is back-pressured while a word waits.
module ascii_hex_parser
  import ascii_hex_pkg::*;
#(
  parameter int NIBBLES = 8,
  parameter int CNT_W   = $clog2(NIBBLES + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_char_valid,
  input  logic [7:0]             i_char,
  output logic                   o_char_ready,
  output logic                   o_word_valid,
  output logic [4*NIBBLES-1:0]   o_word,
  output logic [CNT_W-1:0]       o_word_digits,
  input  logic                   i_word_ready,
  output logic                   o_err
);

  localparam int W = 4 * NIBBLES;

  parse_state_t     state_q, state_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     word_q, word_d;
  logic [CNT_W-1:0] digits_q, digits_d;
  logic             err_q, err_d;

  logic             is_hex;
  logic             is_term;
  logic [3:0]       nibble;
  logic [W-1:0]     acc_new;
  logic [CNT_W-1:0] cnt_new;

  hex_char_decode u_decode (
    .i_char    (i_char),
    .o_is_hex  (is_hex),
    .o_is_term (is_term),
    .o_nibble  (nibble)
  );

  assign acc_new = (acc_q << 4) | W'(nibble);
  assign cnt_new = cnt_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    digits_d = digits_q;
    err_d    = 1'b0;
    case (state_q)
      ACCUM: begin
        if (i_char_valid) begin
          if (is_hex) begin
            if (cnt_new == CNT_W'(NIBBLES)) begin
              word_d   = acc_new;
              digits_d = CNT_W'(NIBBLES);
              acc_d    = '0;
              cnt_d    = '0;
              state_d  = HOLD;
            end else begin
              acc_d = acc_new;
              cnt_d = cnt_new;
            end
          end else if (is_term) begin
            // A terminator with no pending digits is swallowed
            if (cnt_q != '0) begin
              word_d   = acc_q;
              digits_d = cnt_q;
              acc_d    = '0;
              cnt_d    = '0;
              state_d  = HOLD;
            end
          end else begin
            err_d = 1'b1;
            acc_d = '0;
            cnt_d = '0;
          end
        end
      end
      HOLD: begin
        if (i_word_ready) begin
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ACCUM;
      acc_q    <= '0;
      cnt_q    <= '0;
      word_q   <= '0;
      digits_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      digits_q <= digits_d;
      err_q    <= err_d;
    end
  end

  assign o_char_ready  = (state_q == ACCUM);
  assign o_word_valid  = (state_q == HOLD);
  assign o_word        = word_q;
  assign o_word_digits = digits_q;
  assign o_err         = err_q;

endmodule
